// File: rtl/divider_pkg.sv
// ---------------------------------------------------------------------------
// divider_pkg
//   Shared definitions for the restoring divider:
//     - state_t   : divider FSM encoding (IDLE, BUSY, FIX, DONE)
//     - neg()     : two's complement negation
//     - abs_mag() : unsigned magnitude of a two's complement value
//   The helpers work on a fixed DIV_MAX_W-bit container. Callers sign-extend
//   narrower operands into it and size-cast the result back down, so one pair
//   of functions serves any DATA_WIDTH up to DIV_MAX_W.
// ---------------------------------------------------------------------------
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DIV_MAX_W = 64;

  function automatic logic [DIV_MAX_W-1:0] neg(input logic [DIV_MAX_W-1:0] x);
    return ~x + DIV_MAX_W'(1);
  endfunction

  // For the most negative W-bit value the sign-extended negation yields
  // 2^(W-1), which still fits in W bits as an unsigned magnitude.
  function automatic logic [DIV_MAX_W-1:0] abs_mag(input logic [DIV_MAX_W-1:0] x);
    return x[DIV_MAX_W-1] ? neg(x) : x;
  endfunction

endpackage

// File: rtl/comparator.sv
// ---------------------------------------------------------------------------
// comparator
//   Single compare/subtract cell of the restoring divider.
//   Ports:
//     Din_L          in  DATA_WIDTH+1  shifted partial remainder
//     Din_R          in  DATA_WIDTH    divisor magnitude
//     Dout           out DATA_WIDTH    next partial remainder
//     isGreaterEqual out 1             Din_L >= Din_R (the quotient bit)
// ---------------------------------------------------------------------------
module comparator #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH:0]   Din_L,
  input  logic [DATA_WIDTH-1:0] Din_R,
  output logic [DATA_WIDTH-1:0] Dout,
  output logic                  isGreaterEqual
);

  logic                  w_ge;
  logic [DATA_WIDTH-1:0] w_diff_lo;

  assign w_ge = (Din_L >= {1'b0, Din_R});

  // Only the low W bits of the difference are kept; modulo-2^W subtraction
  // of the low halves gives exactly those bits.
  assign w_diff_lo = Din_L[DATA_WIDTH-1:0] - Din_R;

  assign Dout           = w_ge ? w_diff_lo : Din_L[DATA_WIDTH-1:0];
  assign isGreaterEqual = w_ge;

endmodule

// File: rtl/restoring_divider.sv
// ---------------------------------------------------------------------------
// restoring_divider
//   Multi-cycle signed divider, one quotient bit per clock (MSB first).
//   Quotient truncates toward zero; remainder takes the dividend's sign.
//   Handshake: a transfer happens on a rising edge where valid && ready are
//   both high. in_ready and out_valid are decoded from state only; neither
//   depends combinationally on in_valid or out_ready. Once out_valid is high
//   the result holds stable until it is taken.
//   Ports:
//     clock, reset             rising-edge clock, synchronous active-high reset
//     in_valid / in_ready      operand handshake
//     dividend, divisor        signed operands, sampled on the accept edge
//     out_valid / out_ready    result handshake
//     quotient, remainder      signed results
//     div_by_zero              divisor was zero for this result
//     dbg_state                current FSM state (observation only)
//   Timing: accept edge 0, iterations on edges 1..W, sign fixup on edge W+1,
//   out_valid high after edge W+1. A zero divisor skips the iterations and
//   produces its result after edge 1.
// ---------------------------------------------------------------------------
module restoring_divider
  import divider_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_by_zero,
  output state_t                dbg_state
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_dshift;     // dividend magnitude, becomes quotient
  logic [DATA_WIDTH-1:0] r_dmag;       // divisor magnitude
  logic [DATA_WIDTH-1:0] r_prem;       // partial remainder
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_sign_a;     // dividend sign
  logic                  r_sign_b;     // divisor sign
  logic                  r_zero;       // divisor was zero
  logic [DATA_WIDTH-1:0] r_quotient;
  logic [DATA_WIDTH-1:0] r_remainder;
  logic                  r_dbz;

  logic [DATA_WIDTH:0]   w_cmp_in;
  logic [DATA_WIDTH-1:0] w_next_prem;
  logic                  w_qbit;
  logic [DATA_WIDTH-1:0] w_dividend_mag;
  logic [DATA_WIDTH-1:0] w_divisor_mag;
  logic [DATA_WIDTH-1:0] w_q_fixed;
  logic [DATA_WIDTH-1:0] w_r_fixed;

  assign w_dividend_mag = DATA_WIDTH'(abs_mag(DIV_MAX_W'($signed(dividend))));
  assign w_divisor_mag  = DATA_WIDTH'(abs_mag(DIV_MAX_W'($signed(divisor))));

  assign w_cmp_in = {r_prem, r_dshift[DATA_WIDTH-1]};

  comparator #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_cmp (
    .Din_L          (w_cmp_in),
    .Din_R          (r_dmag),
    .Dout           (w_next_prem),
    .isGreaterEqual (w_qbit)
  );

  // Sign fixup. For -2^(W-1) / -1 the magnitude 2^(W-1) passes through
  // un-negated, which is the defined wrap-around result.
  assign w_q_fixed = (r_sign_a ^ r_sign_b)
                   ? DATA_WIDTH'(neg(DIV_MAX_W'(r_dshift)))
                   : r_dshift;
  assign w_r_fixed = r_sign_a
                   ? DATA_WIDTH'(neg(DIV_MAX_W'(r_prem)))
                   : r_prem;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_dshift    <= '0;
      r_dmag      <= '0;
      r_prem      <= '0;
      r_cnt       <= '0;
      r_sign_a    <= 1'b0;
      r_sign_b    <= 1'b0;
      r_zero      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_dmag   <= w_divisor_mag;
            r_sign_a <= dividend[DATA_WIDTH-1];
            r_sign_b <= divisor[DATA_WIDTH-1];
            r_cnt    <= '0;
            if (divisor == '0) begin
              // Preload so the fixup stage yields quotient 0 and
              // remainder = dividend with no special datapath.
              r_zero   <= 1'b1;
              r_dshift <= '0;
              r_prem   <= w_dividend_mag;
              r_state  <= FIX;
            end else begin
              r_zero   <= 1'b0;
              r_dshift <= w_dividend_mag;
              r_prem   <= '0;
              r_state  <= BUSY;
            end
          end
        end

        BUSY: begin
          r_prem   <= w_next_prem;
          r_dshift <= {r_dshift[DATA_WIDTH-2:0], w_qbit};
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(DATA_WIDTH - 1)) begin
            r_state <= FIX;
          end
        end

        FIX: begin
          r_quotient  <= w_q_fixed;
          r_remainder <= w_r_fixed;
          r_dbz       <= r_zero;
          r_state     <= DONE;
        end

        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE) && !reset;
  assign out_valid   = (r_state == DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_restoring_divider.sv
module tb_restoring_divider;
  import divider_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  state_t       dbg_state;

  always #5 clock = ~clock;

  restoring_divider #(.DATA_WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int               n_checks = 0;
  int               n_err = 0;
  logic [2*W:0]     exp_q[$];   // {div_by_zero, quotient, remainder}
  logic             mon_en = 1'b0;
  logic             saw_valid = 1'b0;

  always @(posedge clock) begin
    if (mon_en && out_valid) saw_valid <= 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edbz, input int elat);
    logic [2*W:0] e;
    int n;
    exp_q.push_back({edbz, eq, er});
    @(negedge clock);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (n < 100 && !out_valid) begin
      @(posedge clock);
      #1;
      n++;
    end
    e = exp_q.pop_front();
    chk({tag, "_lat"}, 64'(n), 64'(elat));
    chk({tag, "_q"}, 64'(quotient), 64'(e[2*W-1:W]));
    chk({tag, "_r"}, 64'(remainder), 64'(e[W-1:0]));
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'(e[2*W]));
    @(posedge clock);
    #1;
    chk({tag, "_valid_drop"}, 64'(out_valid), 64'(0));
  endtask

  typedef struct {
    string        tag;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
  } vec_t;

  vec_t vecs[10];

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{"p100_p7",   32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33};
    vecs[1] = '{"n100_p7",   32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 33};
    vecs[2] = '{"p100_n7",   32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0, 33};
    vecs[3] = '{"n100_n7",   32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0, 33};
    vecs[4] = '{"m1_p1",     32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 33};
    vecs[5] = '{"p5_z",      32'd5,          32'd0,          32'd0,          32'd5,          1'b0, 1};
    vecs[6] = '{"min_m1",    32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 33};
    vecs[7] = '{"min_p1",    32'h80000000,   32'd1,          32'h80000000,   32'd0,          1'b0, 33};
    vecs[8] = '{"p7_p100",   32'd7,          32'd100,        32'd0,          32'd7,          1'b0, 33};
    vecs[9] = '{"n9_z",      32'hFFFFFFF7,   32'd0,          32'd0,          32'hFFFFFFF7,   1'b0, 1};
    vecs[5].dbz = 1'b1;
    vecs[9].dbz = 1'b1;

    // reset state
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_q", 64'(quotient), 64'(0));
    chk("rst_r", 64'(remainder), 64'(0));
    chk("rst_dbz", 64'(div_by_zero), 64'(0));
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_release_ready", 64'(in_ready), 64'(1));

    // directed vectors
    foreach (vecs[i]) begin
      run_div(vecs[i].tag, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].lat);
    end

    // backpressure: result held while out_ready is low, new operands ignored
    out_ready = 1'b0;
    begin
      int n;
      @(negedge clock);
      in_valid = 1'b1;
      dividend = 32'd1000;
      divisor  = 32'd3;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      n = 0;
      while (n < 100 && !out_valid) begin
        @(posedge clock);
        #1;
        n++;
      end
      chk("bp_lat", 64'(n), 64'(33));
      for (int k = 0; k < 10; k++) begin
        @(negedge clock);
        in_valid = 1'b1;
        dividend = W'($urandom_range(1, 5000));
        divisor  = W'($urandom_range(1, 9));
        @(posedge clock);
        #1;
        chk("bp_valid", 64'(out_valid), 64'(1));
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        chk("bp_q", 64'(quotient), 64'(333));
        chk("bp_r", 64'(remainder), 64'(1));
      end
      @(negedge clock);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clock);
      #1;
      chk("bp_release_state", 64'(dbg_state), 64'(IDLE));
      chk("bp_release_valid", 64'(out_valid), 64'(0));
      repeat (3) begin
        @(posedge clock);
        #1;
        chk("bp_no_accept", 64'(dbg_state), 64'(IDLE));
      end
    end

    // reset at iteration 10 of 1000/3
    @(negedge clock);
    in_valid = 1'b1;
    dividend = 32'd1000;
    divisor  = 32'd3;
    @(posedge clock);
    #1;
    in_valid  = 1'b0;
    saw_valid = 1'b0;
    mon_en    = 1'b1;
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("mr_in_ready_in_reset", 64'(in_ready), 64'(0));
    chk("mr_state", 64'(dbg_state), 64'(IDLE));
    chk("mr_out_valid", 64'(out_valid), 64'(0));
    chk("mr_q", 64'(quotient), 64'(0));
    chk("mr_r", 64'(remainder), 64'(0));
    chk("mr_dbz", 64'(div_by_zero), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("mr_in_ready_after", 64'(in_ready), 64'(1));
    repeat (40) @(posedge clock);
    #1;
    chk("mr_no_valid", 64'(saw_valid), 64'(0));
    mon_en = 1'b0;
    run_div("mr_follow", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 33);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
